// File: rtl/int_arb.sv
// int_arb: interrupt arbiter feeding the LC-3 interrupt controller's vector/priority inputs.
// Define INT_ARB_RR_EN for round-robin tie-breaking among equal priorities (default: lowest index wins).
module int_arb #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               cfg_wr_en,
    input  logic [SRC_W-1:0]   cfg_sel,
    input  logic [15:0]        bus,
    input  logic               int_ack,
    output logic               int_req,
    output logic [7:0]         int_vec,
    output logic [2:0]         int_priority,
    output logic [SRC_W-1:0]   int_src,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {IDLE, ARB, PRESENT} state_t;

    state_t                    state_q, state_d;
    logic [NUM_SRC-1:0]        en_q, en_d;
    logic [NUM_SRC-1:0][2:0]   pri_q, pri_d;
    logic [NUM_SRC-1:0][7:0]   vec_q, vec_d;
    logic [NUM_SRC-1:0]        req_prev_q, req_prev_d;
    logic [NUM_SRC-1:0]        pending_q, pending_d;
    logic                      int_req_q, int_req_d;
    logic [7:0]                int_vec_q, int_vec_d;
    logic [2:0]                int_pri_q, int_pri_d;
    logic [SRC_W-1:0]          int_src_q, int_src_d;

    logic [NUM_SRC-1:0]        req_set, req_clr, eligible;
    logic                      any_elig, win_elig, higher_exists;
    logic [2:0]                best_pri;
    logic [7:0]                best_vec;
    logic [SRC_W-1:0]          best_idx;
    logic                      unused_bus;

    assign unused_bus = ^bus[14:11];

`ifdef INT_ARB_RR_EN
    logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin
        en_d       = en_q;
        pri_d      = pri_q;
        vec_d      = vec_q;
        req_clr    = '0;
        req_set    = src_req & ~req_prev_q;
        req_prev_d = src_req;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_wr_en && cfg_sel == SRC_W'(i)) begin
                en_d[i]  = bus[15];
                pri_d[i] = bus[10:8];
                vec_d[i] = bus[7:0];
                if (!bus[15])
                    req_clr[i] = 1'b1;
            end
            if (state_q == PRESENT && int_ack && int_src_q == SRC_W'(i))
                req_clr[i] = 1'b1;
        end
        // A fresh edge wins over any clear hitting the same bit this cycle.
        pending_d = (pending_q & ~req_clr) | req_set;
    end

    always_comb begin
        eligible      = '0;
        win_elig      = 1'b0;
        higher_exists = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending_q[i] && en_q[i] && (pri_q[i] != 3'd0);
            if (eligible[i] && int_src_q == SRC_W'(i))
                win_elig = 1'b1;
            if (eligible[i] && int_src_q != SRC_W'(i) && pri_q[i] > int_pri_q)
                higher_exists = 1'b1;
        end
        any_elig = |eligible;
    end

`ifdef INT_ARB_RR_EN
    always_comb begin
        int idx;
        idx      = 0;
        best_pri = 3'd0;
        best_vec = 8'h00;
        best_idx = '0;
        // Strict '>' means the first hit in search order (from the pointer) wins ties.
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC)
                idx = idx - NUM_SRC;
            if (eligible[idx] && pri_q[idx] > best_pri) begin
                best_pri = pri_q[idx];
                best_vec = vec_q[idx];
                best_idx = SRC_W'(idx);
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (state_q == PRESENT && int_ack)
            rr_ptr_d = (int_src_q == SRC_W'(NUM_SRC - 1)) ? '0 : int_src_q + 1'b1;
    end
`else
    always_comb begin
        best_pri = 3'd0;
        best_vec = 8'h00;
        best_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && pri_q[i] > best_pri) begin
                best_pri = pri_q[i];
                best_vec = vec_q[i];
                best_idx = SRC_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        int_vec_d = int_vec_q;
        int_pri_d = int_pri_q;
        int_src_d = int_src_q;
        case (state_q)
            IDLE: begin
                int_req_d = 1'b0;
                int_pri_d = 3'd0;
                if (any_elig)
                    state_d = ARB;
            end
            ARB: begin
                if (any_elig) begin
                    state_d   = PRESENT;
                    int_req_d = 1'b1;
                    int_vec_d = best_vec;
                    int_pri_d = best_pri;
                    int_src_d = best_idx;
                end else begin
                    state_d   = IDLE;
                    int_req_d = 1'b0;
                    int_pri_d = 3'd0;
                end
            end
            PRESENT: begin
                // Ack is checked first so it always beats preemption.
                if (int_ack || !win_elig) begin
                    state_d   = IDLE;
                    int_req_d = 1'b0;
                    int_pri_d = 3'd0;
                end else if (higher_exists) begin
                    state_d   = ARB;
                    int_req_d = 1'b0;
                    int_pri_d = 3'd0;
                end
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
                int_pri_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            en_q       <= '0;
            pri_q      <= '0;
            vec_q      <= '0;
            req_prev_q <= '0;
            pending_q  <= '0;
            int_req_q  <= 1'b0;
            int_vec_q  <= 8'h00;
            int_pri_q  <= 3'd0;
            int_src_q  <= '0;
`ifdef INT_ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            pri_q      <= pri_d;
            vec_q      <= vec_d;
            req_prev_q <= req_prev_d;
            pending_q  <= pending_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            int_pri_q  <= int_pri_d;
            int_src_q  <= int_src_d;
`ifdef INT_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign int_req      = int_req_q;
    assign int_vec      = int_vec_q;
    assign int_priority = int_pri_q;
    assign int_src      = int_src_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_int_arb.sv
// tb_int_arb: scoreboard bench for int_arb; expected presentations are queued as stimulus is driven.
// Tie expectations follow INT_ARB_RR_EN when the bench is built with it.
module tb_int_arb;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] src_req;
    logic               cfg_wr_en;
    logic [SRC_W-1:0]   cfg_sel;
    logic [15:0]        bus;
    logic               int_ack;
    logic               int_req;
    logic [7:0]         int_vec;
    logic [2:0]         int_priority;
    logic [SRC_W-1:0]   int_src;
    logic [NUM_SRC-1:0] pending;

    typedef struct packed {
        logic [7:0]       vec;
        logic [2:0]       pri;
        logic [SRC_W-1:0] src;
    } exp_t;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    int_arb #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_req      (src_req),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_sel      (cfg_sel),
        .bus          (bus),
        .int_ack      (int_ack),
        .int_req      (int_req),
        .int_vec      (int_vec),
        .int_priority (int_priority),
        .int_src      (int_src),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input int sel, input logic en, input logic [2:0] pri, input logic [7:0] vec);
        cfg_wr_en = 1'b1;
        cfg_sel   = SRC_W'(sel);
        bus       = {en, 4'b0000, pri, vec};
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic applyStimulus(input logic [NUM_SRC-1:0] mask);
        src_req = mask;
        step();
        src_req = '0;
    endtask

    task automatic expectPresent(input logic [7:0] vec, input logic [2:0] pri, input int src);
        exp_t e;
        e.vec = vec;
        e.pri = pri;
        e.src = SRC_W'(src);
        exp_q.push_back(e);
    endtask

    task automatic waitPresent(input string tag);
        exp_t e;
        for (int i = 0; i < 20 && !int_req; i++)
            step();
        if (exp_q.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        if (!int_req) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_vec"}, int_vec, e.vec);
        checkOutput({tag, "_pri"}, int_priority, e.pri);
        checkOutput({tag, "_src"}, int_src, e.src);
    endtask

    task automatic ackPresent(input string tag);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checkOutput({tag, "_req_drop"}, int_req, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        src_req   = '0;
        cfg_wr_en = 1'b0;
        cfg_sel   = '0;
        bus       = '0;
        int_ack   = 1'b0;
        doReset();
        step();
        checkOutput("rst_req", int_req, 1'b0);
        checkOutput("rst_vec", int_vec, 8'h00);
        checkOutput("rst_pri", int_priority, 3'd0);
        checkOutput("rst_src", int_src, 2'd0);
        checkOutput("rst_pending", pending, 4'b0000);

        $display("[TB] basic present/ack");
        cfgWrite(1, 1'b1, 3'd4, 8'h80);
        src_req[1] = 1'b1;
        step();
        src_req = '0;
        checkOutput("t1_pending", pending[1], 1'b1);
        step();
        checkOutput("t1_arb_noreq", int_req, 1'b0);
        step();
        checkOutput("t1_latency", int_req, 1'b1);
        expectPresent(8'h80, 3'd4, 1);
        waitPresent("t1");
        cfgWrite(1, 1'b1, 3'd7, 8'h90);
        step();
        checkOutput("t1_hold_vec", int_vec, 8'h80);
        checkOutput("t1_hold_pri", int_priority, 3'd4);
        ackPresent("t1_ack");
        checkOutput("t1_pending_clr", pending[1], 1'b0);

        $display("[TB] priority select");
        cfgWrite(0, 1'b1, 3'd2, 8'h81);
        cfgWrite(2, 1'b1, 3'd6, 8'h82);
        expectPresent(8'h82, 3'd6, 2);
        expectPresent(8'h81, 3'd2, 0);
        applyStimulus(4'b0101);
        waitPresent("t2_first");
        ackPresent("t2_ack1");
        checkOutput("t2_pri_idle", int_priority, 3'd0);
        waitPresent("t2_second");
        ackPresent("t2_ack2");

        $display("[TB] preemption");
        cfgWrite(3, 1'b1, 3'd5, 8'h83);
        expectPresent(8'h81, 3'd2, 0);
        applyStimulus(4'b0001);
        waitPresent("t3_low");
        applyStimulus(4'b1000);
        checkOutput("t3_still_req", int_req, 1'b1);
        step();
        checkOutput("t3_arb_drop", int_req, 1'b0);
        checkOutput("t3_arb_pri", int_priority, 3'd0);
        expectPresent(8'h83, 3'd5, 3);
        waitPresent("t3_high");
        checkOutput("t3_src0_pending", pending[0], 1'b1);
        ackPresent("t3_ack_high");
        expectPresent(8'h81, 3'd2, 0);
        waitPresent("t3_low_again");
        ackPresent("t3_ack_low");

        $display("[TB] masking");
        cfgWrite(1, 1'b1, 3'd0, 8'h80);
        applyStimulus(4'b0010);
        for (int i = 0; i < 4; i++) step();
        checkOutput("t4_pri0_req", int_req, 1'b0);
        checkOutput("t4_pri0_pri", int_priority, 3'd0);
        checkOutput("t4_pri0_pending", pending[1], 1'b1);
        cfgWrite(1, 1'b0, 3'd4, 8'h80);
        checkOutput("t4_dis_clr", pending[1], 1'b0);
        applyStimulus(4'b0010);
        for (int i = 0; i < 3; i++) step();
        checkOutput("t4_dis_req", int_req, 1'b0);
        expectPresent(8'h80, 3'd4, 1);
        cfgWrite(1, 1'b1, 3'd4, 8'h80);
        waitPresent("t4_enabled");
        cfgWrite(1, 1'b0, 3'd4, 8'h80);
        checkOutput("t4_live_clr", pending[1], 1'b0);
        step();
        checkOutput("t4_live_idle", int_req, 1'b0);

        $display("[TB] simultaneous events");
        cfgWrite(1, 1'b1, 3'd4, 8'h80);
        expectPresent(8'h80, 3'd4, 1);
        applyStimulus(4'b0010);
        waitPresent("t5_first");
        int_ack    = 1'b1;
        src_req[1] = 1'b1;
        step();
        int_ack = 1'b0;
        src_req = '0;
        checkOutput("t5_set_wins", pending[1], 1'b1);
        checkOutput("t5_ack_drop", int_req, 1'b0);
        expectPresent(8'h80, 3'd4, 1);
        waitPresent("t5_repeat");
        ackPresent("t5_ack");
        cfgWrite(1, 1'b1, 3'd0, 8'h80);
        applyStimulus(4'b0010);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        checkOutput("t5_idle_ack_pending", pending[1], 1'b1);
        checkOutput("t5_idle_ack_req", int_req, 1'b0);
        cfgWrite(1, 1'b0, 3'd0, 8'h00);

        $display("[TB] tie-break");
        doReset();
        cfgWrite(0, 1'b1, 3'd3, 8'h81);
        cfgWrite(2, 1'b1, 3'd3, 8'h82);
        applyStimulus(4'b0101);
        for (int r = 0; r < 6; r++) begin
`ifdef INT_ARB_RR_EN
            w = (r % 2 == 0) ? 0 : 2;
`else
            w = 0;
`endif
            expectPresent((w == 0) ? 8'h81 : 8'h82, 3'd3, w);
            waitPresent($sformatf("t6_round%0d", r));
            int_ack    = 1'b1;
            src_req[w] = 1'b1;
            step();
            int_ack = 1'b0;
            src_req = '0;
        end
        expectPresent(8'h81, 3'd3, 0);
        waitPresent("t6_final");

        $display("[TB] reset mid-present");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t7_req", int_req, 1'b0);
        checkOutput("t7_vec", int_vec, 8'h00);
        checkOutput("t7_pri", int_priority, 3'd0);
        checkOutput("t7_src", int_src, 2'd0);
        checkOutput("t7_pending", pending, 4'b0000);
        step();
        rst = 1'b0;
        step();
        checkOutput("t7_after_req", int_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
